// File: rtl/regfile_sb_if.sv
// Bus between decode/writeback and the scoreboarded register file.
// The master drives requests and addresses; the slave returns read data and busy state.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic                  wen;
    logic [ADDR_W-1:0]     waddr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic [ADDR_W-1:0]     raddr1;
    logic [ADDR_W-1:0]     raddr2;
    logic [DATA_W-1:0]     rdata1;
    logic [DATA_W-1:0]     rdata2;
    logic                  rbusy1;
    logic                  rbusy2;
    logic                  issue_valid;
    logic [ADDR_W-1:0]     issue_addr;
    logic [ADDR_W:0]       busy_cnt;
    logic [ADDR_W-1:0]     test_addr;
    logic [DATA_W-1:0]     test_data;
    logic                  test_busy;

    modport master (
        output wen, waddr, wdata, wstrb, raddr1, raddr2, issue_valid, issue_addr, test_addr,
        input  rdata1, rdata2, rbusy1, rbusy2, busy_cnt, test_data, test_busy
    );

    modport slave (
        input  wen, waddr, wdata, wstrb, raddr1, raddr2, issue_valid, issue_addr, test_addr,
        output rdata1, rdata2, rbusy1, rbusy2, busy_cnt, test_data, test_busy
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with byte-strobe writes, optional write-to-read bypass and a
// per-register pending-write scoreboard with a registered busy count.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic          clk,
    input  logic          resetn,
    regfile_sb_if.slave   bus
);
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] rf [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic [ADDR_W:0]   busy_count;
    logic [ADDR_W:0]   count_nxt;

    logic              wr_en;
    logic              iss_en;
    logic              cnt_inc;
    logic              cnt_dec;
    logic [DATA_W-1:0] wr_merged;
    logic              hit1, hit2;
    logic              zero1, zero2;

    function automatic logic [DATA_W-1:0] merge(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        for (int i = 0; i < STRB_W; i++)
            res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        return res;
    endfunction

    // Register 0 swallows writes and issues so its busy bit can never set.
    assign wr_en  = bus.wen && !(ZERO_REG != 0 && bus.waddr == '0);
    assign iss_en = bus.issue_valid && !(ZERO_REG != 0 && bus.issue_addr == '0);

    assign wr_merged = merge(rf[bus.waddr], bus.wdata, bus.wstrb);

    // Issue is applied after the clear so a newer producer keeps the bit set.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        busy_nxt = busy;
        if (wr_en)
            busy_nxt[bus.waddr] = 1'b0;
        if (iss_en)
            busy_nxt[bus.issue_addr] = 1'b1;
    end

    assign cnt_inc   = iss_en && !busy[bus.issue_addr];
    assign cnt_dec   = wr_en && busy[bus.waddr] && !(iss_en && bus.issue_addr == bus.waddr);
    assign count_nxt = busy_count + {{ADDR_W{1'b0}}, cnt_inc} - {{ADDR_W{1'b0}}, cnt_dec};

    // NOTE: non-blocking assignments for all clocked state; the array is reset
    // explicitly because post-reset reads must return 0, which rules out a RAM macro.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++)
                rf[i] <= '0;
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (wr_en)
                rf[bus.waddr] <= wr_merged;
            busy       <= busy_nxt;
            busy_count <= count_nxt;
        end
    end

    assign zero1 = (ZERO_REG != 0) && bus.raddr1 == '0;
    assign zero2 = (ZERO_REG != 0) && bus.raddr2 == '0;
    assign hit1  = (BYPASS != 0) && bus.wen && bus.waddr == bus.raddr1;
    assign hit2  = (BYPASS != 0) && bus.wen && bus.waddr == bus.raddr2;

    assign bus.rdata1 = zero1 ? '0 : hit1 ? merge(rf[bus.raddr1], bus.wdata, bus.wstrb) : rf[bus.raddr1];
    assign bus.rdata2 = zero2 ? '0 : hit2 ? merge(rf[bus.raddr2], bus.wdata, bus.wstrb) : rf[bus.raddr2];
    assign bus.rbusy1 = !zero1 && busy[bus.raddr1] && !hit1;
    assign bus.rbusy2 = !zero2 && busy[bus.raddr2] && !hit2;

    // The debug port shows committed state only.
    assign bus.test_data = rf[bus.test_addr];
    assign bus.test_busy = busy[bus.test_addr];
    assign bus.busy_cnt  = busy_count;
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with byte-strobe writes, optional write-to-read bypass and a per-register pending scoreboard for the pipelined CPU. It replaces the fixed 32x32 register file between decode (read/issue) and writeback (write/clear). A debug test port drives the board display. Reads are combinational; writes, scoreboard updates and reset are synchronous to `clk`.

## Interface
- DATA_W, 32, register width in bits; must be a multiple of 8
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and issues
- BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports
- clk  in  1  clock; all state changes on the rising edge
- resetn  in  1  reset, synchronous, active-low
- wen  in  1  writeback write enable
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- wstrb  in  DATA_W/8  byte enables; bit i covers wdata[8i+7:8i]
- raddr1, raddr2  in  ADDR_W  read addresses
- rdata1, rdata2  out  DATA_W  read data
- rbusy1, rbusy2  out  1  addressed register has a pending write
- issue_valid  in  1  decode issued an instruction that will write issue_addr
- issue_addr  in  ADDR_W  destination being reserved
- busy_cnt  out  ADDR_W+1  number of busy registers
- test_addr  in  ADDR_W  debug read address
- test_data  out  DATA_W  debug read data; never bypassed
- test_busy  out  1  busy bit of test_addr

## Operation
- Storage: DEPTH x DATA_W array `rf` and a DEPTH-bit vector `busy`.
- Reset (resetn=0 at the edge):
  - all rf entries, all busy bits and busy_cnt go to 0 in one cycle;
  - reset wins over wen and issue_valid in the same cycle.
- Write, when wen=1:
  - rf[waddr] byte i is updated only where wstrb[i]=1; other bytes are held;
  - wstrb=0 writes no data but still performs the busy clear;
  - with ZERO_REG=1, waddr=0 is ignored entirely.
- Read, for port k with address a:
  - if ZERO_REG and a=0, data is 0;
  - otherwise, if BYPASS and wen and waddr=a, data is the merged value: wdata bytes where wstrb=1, rf[a] bytes elsewhere;
  - otherwise, data is rf[a].
- Scoreboard, per address x:
  - set = issue_valid & issue_addr=x;
  - clr = wen & waddr=x;
  - next busy[x] = set ? 1 : (clr ? 0 : busy[x]); issue wins over a same-cycle writeback because a newer producer is in flight;
  - with ZERO_REG=1, busy[0] stays 0.
- Busy outputs:
  - rbusyk = busy[a] & ~(BYPASS & wen & waddr=a);
  - rbusyk is forced to 0 for register 0 when ZERO_REG=1;
  - test_busy = busy[test_addr], with no bypass.
- Busy count:
  - busy_cnt is registered and equals popcount(busy) at all times;
  - +1 when a clear bit is set; -1 when a set bit is cleared and not re-set;
  - an issue to an already-busy register does not change the count;
  - a writeback to a non-busy register does not change the count;
  - issue and writeback in the same cycle to different addresses apply both changes (net 0 when both bits change).
- busy_cnt cannot overflow: ADDR_W+1 bits hold DEPTH.

## Timing
- Write latency:
  - rf update is visible on rdata and test_data in the cycle after the edge;
  - with BYPASS=1, rdata also shows it in the same cycle; with BYPASS=0, the same-cycle read returns the old value.
- Issue latency: busy and rbusy assert the cycle after issue_valid.
- Outputs after reset: rdata1/2 = 0, test_data = 0, rbusy1/2 = 0, test_busy = 0, busy_cnt = 0.
- Reset during activity: any in-flight issue or write in the reset cycle is discarded; the next cycle reads as post-reset.
- No handshake back-pressure: the block accepts a write and an issue every cycle.
- Stall decisions belong to the decode stage, which uses rbusy.

## Test plan
- Reset, then read all 32 addresses on both ports and the test port -> all 0; busy_cnt=0.
- Write r5=0x11223344 with wstrb=4'b1111, then r5 with wdata=0xAABBCCDD and wstrb=4'b0101 -> next cycle rdata1 = 0x11BB33DD; during the second write, with BYPASS=1, rdata1 = 0x11BB33DD in the same cycle while test_data=0x11223344.
- Write r0=0xFFFFFFFF and issue r0 -> rdata=0, rbusy=0, busy_cnt=0.
- Issue r3, then r7 -> busy_cnt=2. Writeback r3 in the same cycle as issue r3 -> busy[3] stays 1, busy_cnt=2. Writeback r3 alone -> busy_cnt=1. Read r7 while writing r7 -> rbusy=0 (BYPASS=1), test_busy=1.
- Issue r1 and write r2 (r2 busy) in the same cycle -> busy_cnt unchanged. Then writeback r9 (not busy) -> busy_cnt unchanged.
- Fill all 31 busy bits, then assert resetn=0 together with wen and issue_valid -> next cycle everything is 0 and busy_cnt=0.
